// File: rtl/umai_slave_tx.sv
// umai_slave_tx: transmit half of the UMAI slave bridge.
//
// Takes UMAI write commands, read commands and 512-bit write data words from the local
// slave interface and packs them into 72-bit AIB flits spread across the channel window
// c_first_chn_id..c_last_chn_id. All flits in flight form one "bundle" that is consumed
// all-or-nothing once every valid channel sees ready.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   c_first_chn_id/c_last_chn_id static channel window (first <= last < NumChannels)
//   i_umai_wcmd_*/o_umai_wcmd_ready  write command (addr 32b, len = beats-1 6b)
//   i_umai_rcmd_*/o_umai_rcmd_ready  read command  (addr 32b, len = beats-1 6b)
//   i_umai_wvalid/wdata/o_umai_wready  write data beat, lane k = wdata[64k+63:64k]
//   o_tx_valid/i_tx_ready/o_tx_data  per-channel flit launch (72b per channel, flat)
//
// Optional macro UMAI_SLAVE_TX_PERF_EN adds o_perf_bundles (completed bundles) and
// o_perf_stall (cycles holding an incomplete bundle); both wrap at 2^32.

module umai_slave_tx #(
   parameter int unsigned NumChannels = 6
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [2:0]                  c_first_chn_id,
   input  logic [2:0]                  c_last_chn_id,
   input  logic                        i_umai_wcmd_valid,
   output logic                        o_umai_wcmd_ready,
   input  logic [31:0]                 i_umai_wcmd_addr,
   input  logic [5:0]                  i_umai_wcmd_len,
   input  logic                        i_umai_rcmd_valid,
   output logic                        o_umai_rcmd_ready,
   input  logic [31:0]                 i_umai_rcmd_addr,
   input  logic [5:0]                  i_umai_rcmd_len,
   input  logic                        i_umai_wvalid,
   output logic                        o_umai_wready,
   input  logic [511:0]                i_umai_wdata,
   output logic [NumChannels-1:0]      o_tx_valid,
   input  logic [NumChannels-1:0]      i_tx_ready,
   output logic [72*NumChannels-1:0]   o_tx_data
`ifdef UMAI_SLAVE_TX_PERF_EN
   ,
   output logic [31:0]                 o_perf_bundles,
   output logic [31:0]                 o_perf_stall
`endif
);

   // Holding registers
   logic                       wcmd_vld_q, wcmd_vld_d;
   logic [31:0]                wcmd_addr_q, wcmd_addr_d;
   logic [5:0]                 wcmd_len_q, wcmd_len_d;
   logic                       rcmd_vld_q, rcmd_vld_d;
   logic [31:0]                rcmd_addr_q, rcmd_addr_d;
   logic [5:0]                 rcmd_len_q, rcmd_len_d;
   logic                       wd_vld_q, wd_vld_d;
   logic [511:0]               wd_data_q, wd_data_d;
   logic [2:0]                 lp_q, lp_d;

   // Write beats announced by placed commands but not yet sent
   logic [6:0]                 credit_q, credit_d;
   // Round-robin pointer: 0 favours read, 1 favours write
   logic                       rr_q, rr_d;

   // Launch register
   logic [NumChannels-1:0]     tx_valid_q, tx_valid_d;
   logic [72*NumChannels-1:0]  tx_data_q, tx_data_d;

   logic                       launch_free;
   logic                       wcmd_can;
   logic                       grant_w, grant_r, cmd_placed;
   logic                       w_go, r_go;
   logic                       data_elig, retire;
   logic [3:0]                 first_w, last_w, dfirst_w, nlanes, lp_end;
   logic [3:0]                 chn, lane;
   logic [71:0]                cmd_flit;
   logic [NumChannels-1:0]     bnd_valid;
   logic [72*NumChannels-1:0]  bnd_data;

   // Arbitration and bundle construction
   always_comb begin
      // The stage can take a new bundle if no valid channel is waiting on ready.
      launch_free = ((tx_valid_q & ~i_tx_ready) == '0);

      // Block command placement while credit is high so the 7-bit counter cannot wrap.
      wcmd_can   = wcmd_vld_q & ~credit_q[6];
      grant_w    = wcmd_can & (~rcmd_vld_q | rr_q);
      grant_r    = rcmd_vld_q & (~wcmd_can | ~rr_q);
      cmd_placed = grant_w | grant_r;
      w_go       = launch_free & grant_w;
      r_go       = launch_free & grant_r;

      if (grant_w) begin
         cmd_flit = {2'b11, 32'd0, wcmd_len_q, wcmd_addr_q};
      end else begin
         cmd_flit = {2'b10, 32'd0, rcmd_len_q, rcmd_addr_q};
      end

      first_w  = {1'b0, c_first_chn_id};
      last_w   = {1'b0, c_last_chn_id};
      dfirst_w = first_w + {3'd0, cmd_placed};
      nlanes   = last_w + 4'd1 - dfirst_w;

      // A word may ride with its own wcmd even before credit exists.
      data_elig = wd_vld_q & ((credit_q != 7'd0) | grant_w);
      lp_end    = {1'b0, lp_q} + nlanes;
      retire    = launch_free & data_elig & (lp_end >= 4'd8);

      bnd_valid = '0;
      bnd_data  = '0;
      chn       = 4'd0;
      lane      = 4'd0;
      for (int c = 0; c < int'(NumChannels); c++) begin
         chn = 4'(c);
         if (cmd_placed && (chn == first_w)) begin
            bnd_valid[c]        = 1'b1;
            bnd_data[c*72 +: 72] = cmd_flit;
         end else if (data_elig && (chn >= dfirst_w) && (chn <= last_w)) begin
            lane         = {1'b0, lp_q} + (chn - dfirst_w);
            bnd_valid[c] = 1'b1;
            // Channels past the end of the word go out as valid padding (bit64 = 0).
            if (lane < 4'd8) begin
               bnd_data[c*72 +: 72] = {7'd0, 1'b1, wd_data_q[{lane[2:0], 6'd0} +: 64]};
            end
         end
      end
   end

   // Holding registers, credit, arbitration pointer and launch register next state
   always_comb begin
      o_umai_wcmd_ready = (~wcmd_vld_q | w_go) & ~credit_q[6];
      o_umai_rcmd_ready = ~rcmd_vld_q | r_go;
      o_umai_wready     = ~wd_vld_q | retire;

      wcmd_vld_d  = wcmd_vld_q;
      wcmd_addr_d = wcmd_addr_q;
      wcmd_len_d  = wcmd_len_q;
      if (i_umai_wcmd_valid && o_umai_wcmd_ready) begin
         wcmd_vld_d  = 1'b1;
         wcmd_addr_d = i_umai_wcmd_addr;
         wcmd_len_d  = i_umai_wcmd_len;
      end else if (w_go) begin
         wcmd_vld_d = 1'b0;
      end

      rcmd_vld_d  = rcmd_vld_q;
      rcmd_addr_d = rcmd_addr_q;
      rcmd_len_d  = rcmd_len_q;
      if (i_umai_rcmd_valid && o_umai_rcmd_ready) begin
         rcmd_vld_d  = 1'b1;
         rcmd_addr_d = i_umai_rcmd_addr;
         rcmd_len_d  = i_umai_rcmd_len;
      end else if (r_go) begin
         rcmd_vld_d = 1'b0;
      end

      wd_vld_d  = wd_vld_q;
      wd_data_d = wd_data_q;
      lp_d      = lp_q;
      if (i_umai_wvalid && o_umai_wready) begin
         wd_vld_d  = 1'b1;
         wd_data_d = i_umai_wdata;
         lp_d      = 3'd0;
      end else if (retire) begin
         wd_vld_d = 1'b0;
         lp_d     = 3'd0;
      end else if (launch_free && data_elig) begin
         lp_d = lp_end[2:0];
      end

      credit_d = credit_q;
      if (w_go) begin
         credit_d = credit_d + {1'b0, wcmd_len_q} + 7'd1;
      end
      if (retire) begin
         credit_d = credit_d - 7'd1;
      end

      rr_d = rr_q;
      if (launch_free && cmd_placed) begin
         rr_d = grant_r;
      end

      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      if (launch_free) begin
         tx_valid_d = bnd_valid;
         tx_data_d  = bnd_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wcmd_vld_q  <= 1'b0;
         wcmd_addr_q <= '0;
         wcmd_len_q  <= '0;
         rcmd_vld_q  <= 1'b0;
         rcmd_addr_q <= '0;
         rcmd_len_q  <= '0;
         wd_vld_q    <= 1'b0;
         wd_data_q   <= '0;
         lp_q        <= '0;
         credit_q    <= '0;
         rr_q        <= 1'b0;
         tx_valid_q  <= '0;
         tx_data_q   <= '0;
      end else begin
         wcmd_vld_q  <= wcmd_vld_d;
         wcmd_addr_q <= wcmd_addr_d;
         wcmd_len_q  <= wcmd_len_d;
         rcmd_vld_q  <= rcmd_vld_d;
         rcmd_addr_q <= rcmd_addr_d;
         rcmd_len_q  <= rcmd_len_d;
         wd_vld_q    <= wd_vld_d;
         wd_data_q   <= wd_data_d;
         lp_q        <= lp_d;
         credit_q    <= credit_d;
         rr_q        <= rr_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign o_tx_valid = tx_valid_q;
   assign o_tx_data  = tx_data_q;

`ifdef UMAI_SLAVE_TX_PERF_EN
   logic [31:0] perf_bundles_q, perf_bundles_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_bundles_d = perf_bundles_q;
      perf_stall_d   = perf_stall_q;
      if (tx_valid_q != '0) begin
         if (launch_free) begin
            perf_bundles_d = perf_bundles_q + 32'd1;
         end else begin
            perf_stall_d = perf_stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         perf_bundles_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_bundles_q <= perf_bundles_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign o_perf_bundles = perf_bundles_q;
   assign o_perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_umai_slave_tx.sv
// Testbench for umai_slave_tx: directed timing scenarios plus randomized traffic checked by
// a scoreboard. Drivers push expected command flits and data lanes into queues at each UMAI
// handshake; a monitor pops and checks them whenever a bundle completes.

module tb_umai_slave_tx;
   localparam int NCH = 6;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [2:0]           first_id = 3'd0;
   logic [2:0]           last_id = 3'd5;
   logic                 wcmd_valid = 1'b0, wcmd_ready;
   logic [31:0]          wcmd_addr = '0;
   logic [5:0]           wcmd_len = '0;
   logic                 rcmd_valid = 1'b0, rcmd_ready;
   logic [31:0]          rcmd_addr = '0;
   logic [5:0]           rcmd_len = '0;
   logic                 wvalid = 1'b0, wready;
   logic [511:0]         wdata = '0;
   logic [NCH-1:0]       tx_valid;
   logic [NCH-1:0]       tx_ready = '1;
   logic [72*NCH-1:0]    tx_data;
`ifdef UMAI_SLAVE_TX_PERF_EN
   logic [31:0]          perf_bundles, perf_stall;
`endif

   umai_slave_tx #(.NumChannels(NCH)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .c_first_chn_id    (first_id),
      .c_last_chn_id     (last_id),
      .i_umai_wcmd_valid (wcmd_valid),
      .o_umai_wcmd_ready (wcmd_ready),
      .i_umai_wcmd_addr  (wcmd_addr),
      .i_umai_wcmd_len   (wcmd_len),
      .i_umai_rcmd_valid (rcmd_valid),
      .o_umai_rcmd_ready (rcmd_ready),
      .i_umai_rcmd_addr  (rcmd_addr),
      .i_umai_rcmd_len   (rcmd_len),
      .i_umai_wvalid     (wvalid),
      .o_umai_wready     (wready),
      .i_umai_wdata      (wdata),
      .o_tx_valid        (tx_valid),
      .i_tx_ready        (tx_ready),
      .o_tx_data         (tx_data)
`ifdef UMAI_SLAVE_TX_PERF_EN
      ,
      .o_perf_bundles    (perf_bundles),
      .o_perf_stall      (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [37:0] q_wcmd[$];
   logic [37:0] q_rcmd[$];
   logic [64:0] q_lane[$];   // {last lane of word, lane data}
   bit          cmd_log[$];  // 1 = write command slot, 0 = read
   int          m_credit = 0;
   bit          rnd_ready = 1'b0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_note(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event occurred, none expected", nm);
   endtask

   function automatic logic [71:0] flit(input int ch);
      return tx_data[ch*72 +: 72];
   endfunction

   function automatic logic [511:0] rnd_word();
      logic [511:0] w;
      for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // ---------------- drivers (called at posedge+1, return at posedge+1) ----------------
   task automatic drv_wcmd(input logic [31:0] a, input logic [5:0] l);
      bit ok = 1'b0;
      int n = 0;
      wcmd_valid = 1'b1; wcmd_addr = a; wcmd_len = l;
      while (!ok && n < 3000) begin
         @(negedge clk);
         if (wcmd_ready) begin ok = 1'b1; q_wcmd.push_back({l, a}); end
         @(posedge clk); #1; n++;
      end
      if (!ok) fail_note("wcmd_timeout");
      wcmd_valid = 1'b0;
   endtask

   task automatic drv_rcmd(input logic [31:0] a, input logic [5:0] l);
      bit ok = 1'b0;
      int n = 0;
      rcmd_valid = 1'b1; rcmd_addr = a; rcmd_len = l;
      while (!ok && n < 3000) begin
         @(negedge clk);
         if (rcmd_ready) begin ok = 1'b1; q_rcmd.push_back({l, a}); end
         @(posedge clk); #1; n++;
      end
      if (!ok) fail_note("rcmd_timeout");
      rcmd_valid = 1'b0;
   endtask

   task automatic drv_wd(input logic [511:0] w);
      bit ok = 1'b0;
      int n = 0;
      wvalid = 1'b1; wdata = w;
      while (!ok && n < 3000) begin
         @(negedge clk);
         if (wready) begin
            ok = 1'b1;
            for (int k = 0; k < 8; k++) q_lane.push_back({(k == 7), w[k*64 +: 64]});
         end
         @(posedge clk); #1; n++;
      end
      if (!ok) fail_note("wdata_timeout");
      wvalid = 1'b0;
   endtask

   task automatic clear_model();
      q_wcmd.delete(); q_rcmd.delete(); q_lane.delete(); cmd_log.delete();
      m_credit = 0;
   endtask

   task automatic do_reset(input int f, input int l);
      rst = 1'b1;
      first_id = 3'(f); last_id = 3'(l);
      clear_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic check_bundle();
      logic [NCH-1:0] win, dmask;
      logic [71:0]    f;
      logic [37:0]    e;
      logic [64:0]    ln;
      int             d0;
      bit             has_cmd, ended;
      win = '0;
      for (int c = int'(first_id); c <= int'(last_id); c++) win[c] = 1'b1;
      chk("window", tx_valid & ~win, '0);
      f = flit(int'(first_id));
      has_cmd = tx_valid[first_id] && f[71];
      if (has_cmd) begin
         if (f[70]) begin
            if (q_wcmd.size() == 0) fail_note("wcmd_extra");
            else begin
               e = q_wcmd.pop_front();
               chk("wcmd_flit", f, {2'b11, 32'd0, e});
               m_credit += int'(e[37:32]) + 1;
               cmd_log.push_back(1'b1);
            end
         end else begin
            if (q_rcmd.size() == 0) fail_note("rcmd_extra");
            else begin
               e = q_rcmd.pop_front();
               chk("rcmd_flit", f, {2'b10, 32'd0, e});
               cmd_log.push_back(1'b0);
            end
         end
      end
      d0 = int'(first_id) + (has_cmd ? 1 : 0);
      dmask = '0;
      for (int c = d0; c <= int'(last_id); c++) dmask[c] = 1'b1;
      if ((tx_valid & dmask) != '0) begin
         chk("data_all_valid", tx_valid & dmask, dmask);
         chk("data_credit", m_credit > 0, 1);
         ended = 1'b0;
         for (int c = d0; c <= int'(last_id); c++) begin
            f = flit(c);
            if (ended) chk("data_pad", f, '0);
            else if (q_lane.size() == 0) begin fail_note("lane_extra"); ended = 1'b1; end
            else begin
               ln = q_lane.pop_front();
               chk("data_lane", f, {8'h01, ln[63:0]});
               if (ln[64]) begin ended = 1'b1; m_credit--; end
            end
         end
      end
   endtask

   bit             prev_pend = 1'b0;
   logic [NCH-1:0] prev_v;
   logic [72*NCH-1:0] prev_d;
   always @(negedge clk) begin
      if (rst) begin
         prev_pend = 1'b0;
      end else begin
         bit done;
         if (prev_pend) begin
            chk("hold_valid", tx_valid, prev_v);
            chk("hold_data", tx_data, prev_d);
         end
         done = (tx_valid != '0) && ((tx_valid & ~tx_ready) == '0);
         prev_pend = (tx_valid != '0) && !done;
         prev_v = tx_valid;
         prev_d = tx_data;
         if (done) check_bundle();
      end
   end

   always @(posedge clk) begin
      logic [31:0] r;
      #1;
      if (rnd_ready) begin
         r = $urandom | $urandom;
         tx_ready = r[NCH-1:0];
      end
   end

   // ---------------- random phase ----------------
   task automatic rand_run(input int f, input int l);
      int lens[12];
      int nwords = 0;
      int n = 0;
      do_reset(f, l);
      rnd_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         lens[i] = $urandom_range(0, 3);
         nwords += lens[i] + 1;
      end
      fork
         for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            drv_wcmd($urandom, 6'(lens[i]));
         end
         for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            drv_rcmd($urandom, 6'($urandom_range(0, 63)));
         end
         for (int i = 0; i < nwords; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            drv_wd(rnd_word());
         end
      join
      while ((q_wcmd.size() + q_rcmd.size() + q_lane.size()) != 0 && n < 4000) begin
         @(posedge clk); n++;
      end
      @(negedge clk);
      chk("rand_drain", q_wcmd.size() + q_rcmd.size() + q_lane.size(), 0);
      chk("rand_credit", m_credit, 0);
      rnd_ready = 1'b0;
      @(posedge clk); #1 tx_ready = '1;
      repeat (3) @(posedge clk);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      logic [511:0]      w;
      logic [NCH-1:0]    snap_v;
      logic [72*NCH-1:0] snap_d;

      #12;
      chk("reset_valid", tx_valid, '0);
      chk("reset_data", tx_data, '0);
      do_reset(0, 5);
      chk("reset_readies", {wcmd_ready, rcmd_ready, wready}, 3'b111);

      // Command plus a full word on a six-channel window
      w = rnd_word();
      fork
         drv_wcmd(32'h1000, 6'd0);
         drv_wd(w);
      join
      @(negedge clk);
      chk("t1_latency_gap", tx_valid, '0);
      @(negedge clk);
      chk("t1_b1_valid", tx_valid, 6'h3f);
      chk("t1_b1_cmd", flit(0), {2'b11, 32'd0, 6'd0, 32'h1000});
      for (int c = 1; c < 6; c++) chk("t1_b1_lane", flit(c), {8'h01, w[(c-1)*64 +: 64]});
      @(negedge clk);
      chk("t1_b2_valid", tx_valid, 6'h3f);
      for (int c = 0; c < 3; c++) chk("t1_b2_lane", flit(c), {8'h01, w[(c+5)*64 +: 64]});
      for (int c = 3; c < 6; c++) chk("t1_b2_pad", flit(c), '0);
      @(negedge clk);
      chk("t1_idle", tx_valid, '0);
      @(posedge clk); #1;

      // Data without credit waits for its command
      w = rnd_word();
      drv_wd(w);
      repeat (6) begin
         @(negedge clk);
         chk("t2_blocked", tx_valid, '0);
      end
      chk("t2_entry_held", wready, 1'b0);
      @(posedge clk); #1;
      drv_wcmd(32'h2000, 6'd0);
      @(negedge clk);
      chk("t2_latency_gap", tx_valid, '0);
      @(negedge clk);
      chk("t2_valid", tx_valid, 6'h3f);
      chk("t2_cmd", flit(0), {2'b11, 32'd0, 6'd0, 32'h2000});
      chk("t2_lane0", flit(1), {8'h01, w[63:0]});
      repeat (4) @(posedge clk); #1;

      // Round-robin between back-to-back read and write commands
      do_reset(0, 5);
      fork
         for (int i = 0; i < 6; i++) drv_rcmd(32'h100 + i, 6'd1);
         for (int i = 0; i < 6; i++) drv_wcmd(32'h200 + i, 6'd0);
      join
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("rr_count", cmd_log.size(), 12);
      for (int i = 0; i < cmd_log.size(); i++) chk("rr_order", cmd_log[i], i % 2);
      @(posedge clk); #1;

      // Ready held low on channel 3 for five cycles
      do_reset(0, 5);
      w = rnd_word();
      fork
         drv_wcmd(32'h4000, 6'd0);
         drv_wd(w);
      join
      tx_ready = 6'b110111;
      @(negedge clk);
      @(negedge clk);
      chk("t4_valid", tx_valid, 6'h3f);
      snap_v = tx_valid;
      snap_d = tx_data;
      repeat (4) begin
         @(negedge clk);
         chk("t4_hold_v", tx_valid, snap_v);
         chk("t4_hold_d", tx_data, snap_d);
      end
      @(posedge clk); #1 tx_ready = '1;
      @(negedge clk);
      chk("t4_hold_last", tx_data, snap_d);
      @(negedge clk);
      chk("t4_b2_lane5", flit(0), {8'h01, w[5*64 +: 64]});
      @(negedge clk);
      chk("t4_idle", tx_valid, '0);
`ifdef UMAI_SLAVE_TX_PERF_EN
      chk("t4_perf_stall", perf_stall, 32'd5);
      chk("t4_perf_bundles", perf_bundles, 32'd2);
`endif
      @(posedge clk); #1;

      // Single-channel window
      do_reset(2, 2);
      w = rnd_word();
      fork
         drv_wcmd(32'h5000, 6'd0);
         drv_wd(w);
      join
      @(negedge clk);
      chk("t5_latency_gap", tx_valid, '0);
      @(negedge clk);
      chk("t5_cmd_valid", tx_valid, 6'b000100);
      chk("t5_cmd", flit(2), {2'b11, 32'd0, 6'd0, 32'h5000});
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t5_lane_valid", tx_valid, 6'b000100);
         chk("t5_lane", flit(2), {8'h01, w[k*64 +: 64]});
      end
      @(negedge clk);
      chk("t5_idle", tx_valid, '0);
      @(posedge clk); #1;

      // Reset in the middle of a word with credit 3
      do_reset(0, 5);
      w = rnd_word();
      fork
         drv_wcmd(32'h6000, 6'd2);
         drv_wd(w);
      join
      @(negedge clk);
      @(negedge clk);
      chk("t6_pre_valid", tx_valid, 6'h3f);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", tx_valid, '0);
      chk("t6_rst_data", tx_data, '0);
      clear_model();
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      chk("t6_readies", {wcmd_ready, rcmd_ready, wready}, 3'b111);
      w = rnd_word();
      drv_wd(w);
      repeat (8) begin
         @(negedge clk);
         chk("t6_blocked", tx_valid, '0);
      end
      @(posedge clk); #1;
      drv_wcmd(32'h7000, 6'd0);
      @(negedge clk);
      @(negedge clk);
      chk("t6_resume_valid", tx_valid, 6'h3f);
      chk("t6_resume_lane0", flit(1), {8'h01, w[63:0]});
      repeat (4) @(posedge clk); #1;

      // Randomized traffic across several windows
      rand_run(0, 5);
      rand_run(1, 3);
      rand_run(4, 4);
      rand_run(2, 5);
      rand_run(0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
